// File: rtl/median_filter_system.sv
// Streaming 3x3 median filter over a raster-scanned frame; border pixels pass through.
// A shift-register line buffer forms the window, and a two-stage compare-exchange network selects the median.
module median_filter_system #(
    parameter int unsigned WINDOW_SIZE  = 3,
    parameter int unsigned IMAGE_WIDTH  = 8,
    parameter int unsigned IMAGE_HEIGHT = 8,
    parameter int unsigned PIXEL_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   data_valid,
    input  logic [PIXEL_WIDTH-1:0] data_in,
    output logic                   data_valid_out,
    output logic [PIXEL_WIDTH-1:0] data_out,
    output logic                   frame_complete
);
    localparam int unsigned W      = IMAGE_WIDTH;
    localparam int unsigned H      = IMAGE_HEIGHT;
    localparam int unsigned PW     = PIXEL_WIDTH;
    localparam int unsigned NPIX   = W * H;
    localparam int unsigned NBEATS = NPIX + W + 1;
    localparam int unsigned SR_LEN = (WINDOW_SIZE - 1) * W + WINDOW_SIZE;
    localparam int unsigned CNT_W  = $clog2(NBEATS + 1);
    localparam int unsigned ROW_W  = $clog2(H + 1);
    localparam int unsigned COL_W  = $clog2(W);

    localparam logic [CNT_W-1:0] LAST_REAL = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(NBEATS);
    localparam logic [CNT_W-1:0] FIRST_OUT = CNT_W'(W + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ROW_W-1:0]  r_orow;
    logic [COL_W-1:0]  r_ocol;
    logic [PW-1:0]     r_sr [SR_LEN];
    logic              w_start, w_beat, w_emit, w_border;
    logic              r_v0, r_b0, r_v1, r_b1;
    logic [PW-1:0]     w_lo [3], w_mid [3], w_hi [3];
    logic [PW-1:0]     r_lo [3], r_mid [3], r_hi [3];
    logic [PW-1:0]     r_ctr, w_med;
    logic              r_dvo, r_fc;
    logic [PW-1:0]     r_dout;

    function automatic logic [PW-1:0] min2(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PW-1:0] max2(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [PW-1:0] med3(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                           input logic [PW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (data_valid) w_next = COLLECT;
            COLLECT: if (data_valid && r_cnt == LAST_REAL) w_next = FLUSH;
            FLUSH:   if (r_cnt == CNT_END && !r_v0 && !r_v1 && r_dvo) w_next = DONE;
            DONE:    if (!data_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_start  = (r_state == IDLE) && data_valid;
    assign w_beat   = w_start || ((r_state == COLLECT) && data_valid) ||
                      ((r_state == FLUSH) && (r_cnt < CNT_END));
    assign w_emit   = w_beat && !w_start && (r_cnt >= FIRST_OUT);
    assign w_border = (r_orow == '0) || (r_orow == ROW_W'(H - 1)) ||
                      (r_ocol == '0) || (r_ocol == COL_W'(W - 1));

    // Control state, output counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_orow  <= '0;
            r_ocol  <= '0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_dvo   <= 1'b0;
            r_dout  <= '0;
            r_fc    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cnt  <= CNT_W'(1);
                r_orow <= '0;
                r_ocol <= '0;
                r_fc   <= 1'b0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_emit) begin
                if (r_ocol == COL_W'(W - 1)) begin
                    r_ocol <= '0;
                    r_orow <= r_orow + 1'b1;
                end else begin
                    r_ocol <= r_ocol + 1'b1;
                end
            end
            r_v0  <= w_emit;
            r_v1  <= r_v0;
            r_dvo <= r_v1;
            if (r_v1) r_dout <= r_b1 ? r_ctr : w_med;
            if (r_state == FLUSH && w_next == DONE) r_fc <= 1'b1;
        end
    end

    // Line buffer: r_sr[j] holds the pixel of beat k-j; flush beats shift in zeros
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_sr[0] <= (r_state == FLUSH) ? '0 : data_in;
            for (int j = 1; j < int'(SR_LEN); j++) r_sr[j] <= r_sr[j-1];
        end
    end

    // Stage 1: sort each window row (same source row, so no wrap across rows)
    for (genvar g = 0; g < 3; g++) begin : g_row
        assign w_lo[g]  = min2(min2(r_sr[g*W], r_sr[g*W+1]), r_sr[g*W+2]);
        assign w_mid[g] = med3(r_sr[g*W], r_sr[g*W+1], r_sr[g*W+2]);
        assign w_hi[g]  = max2(max2(r_sr[g*W], r_sr[g*W+1]), r_sr[g*W+2]);
    end

    always_ff @(posedge clk) begin
        r_b0  <= w_border;
        r_b1  <= r_b0;
        r_ctr <= r_sr[W+1];
        for (int i = 0; i < 3; i++) begin
            r_lo[i]  <= w_lo[i];
            r_mid[i] <= w_mid[i];
            r_hi[i]  <= w_hi[i];
        end
    end

    // Stage 2: median = med3(max of lows, median of mids, min of highs)
    assign w_med = med3(max2(max2(r_lo[0], r_lo[1]), r_lo[2]),
                        med3(r_mid[0], r_mid[1], r_mid[2]),
                        min2(min2(r_hi[0], r_hi[1]), r_hi[2]));

    assign data_valid_out = r_dvo;
    assign data_out       = r_dout;
    assign frame_complete = r_fc;

endmodule

// File: tb/tb_median_filter_system.sv
// Self-checking bench for median_filter_system: directed and random frames checked
// against a sort-based 3x3 median reference model.
module tb_median_filter_system;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;

    logic       clk;
    logic       rst_n;
    logic       data_valid;
    logic [7:0] data_in;
    logic       data_valid_out;
    logic [7:0] data_out;
    logic       frame_complete;

    int         n_vec, n_err, cyc;
    int         first_cyc, last_cyc, fc_cyc, first_out_cyc, last_out_cyc;
    logic       fc_at_start;
    logic [7:0] got[$];
    logic [7:0] frame[NPIX];
    logic [7:0] exp_q[NPIX];

    median_filter_system #(
        .WINDOW_SIZE(3), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
        .data_valid_out(data_valid_out), .data_out(data_out), .frame_complete(frame_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid_out) begin
            got.push_back(data_out);
            last_out_cyc = cyc;
            if (got.size() == 1) first_out_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d outputs", got.size());
        $fatal(1, "watchdog");
    end

    // Reference: borders copy the input, interior takes the 5th smallest of the 3x3 window
    function automatic void compute_expected();
        logic [7:0] v[9];
        logic [7:0] t;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
                    exp_q[r*W+c] = frame[r*W+c];
                end else begin
                    for (int i = 0; i < 9; i++) v[i] = frame[(r-1+i/3)*W + (c-1+i%3)];
                    for (int a = 0; a < 9; a++)
                        for (int b = 0; b < 8 - a; b++)
                            if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
                    exp_q[r*W+c] = v[4];
                end
            end
        end
    endfunction

    // gap_mode: 0 continuous, 3 one idle cycle after every third beat, 1 random idles
    task automatic run_frame(input int gap_mode, input int extra);
        int t;
        got.delete();
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clk);
            if (i == 1) fc_at_start = frame_complete;
            data_valid = 1'b1;
            data_in    = frame[i];
            if (i == 0) first_cyc = cyc;
            if (i == NPIX-1) last_cyc = cyc;
            if (i != NPIX-1 && ((gap_mode == 3 && i % 3 == 2) ||
                                (gap_mode == 1 && $urandom_range(0, 3) == 0))) begin
                @(negedge clk);
                data_valid = 1'b0;
                data_in    = 8'($urandom);
            end
        end
        for (int j = 0; j < extra; j++) begin
            @(negedge clk);
            data_valid = 1'b1;
            data_in    = 8'($urandom);
        end
        @(negedge clk);
        data_valid = 1'b0;
        t = 0;
        while (frame_complete !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        fc_cyc = cyc;
        if (frame_complete !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL frame_timeout: frame_complete=%b after %0d cycles, required 1", frame_complete, t);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_valid = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (data_valid_out !== 1'b0 || data_out !== 8'h00 || frame_complete !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: dvo=%b dout=%h fc=%b, required 0/00/0", data_valid_out, data_out, frame_complete);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_constant();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'h55;
        run_frame(0, 0);
        compute_expected();
        n_vec++;
        if (got.size() != NPIX) begin n_err++; $display("FAIL const_count: got %0d outputs, required %0d", got.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            logic [7:0] act;
            act = (i < got.size()) ? got[i] : 8'hxx;
            n_vec++;
            if (act !== exp_q[i]) begin n_err++; $display("FAIL const_pix[%0d]: got %h, required %h", i, act, exp_q[i]); end
        end
        n_vec++;
        if (first_out_cyc - first_cyc !== W + 4) begin
            n_err++; $display("FAIL first_latency: got %0d, required %0d", first_out_cyc - first_cyc, W + 4);
        end
        n_vec++;
        if (last_out_cyc - last_cyc !== W + 4) begin
            n_err++; $display("FAIL last_latency: got %0d, required %0d", last_out_cyc - last_cyc, W + 4);
        end
        n_vec++;
        if (fc_cyc - last_cyc !== W + 5) begin
            n_err++; $display("FAIL fc_timing: got %0d, required %0d", fc_cyc - last_cyc, W + 5);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (frame_complete !== 1'b1) begin n_err++; $display("FAIL fc_sticky: got %b, required 1", frame_complete); end
    endtask

    task automatic test_frame(input string name, input int gap_mode, input int extra);
        run_frame(gap_mode, extra);
        compute_expected();
        n_vec++;
        if (fc_at_start !== 1'b0) begin n_err++; $display("FAIL %s_fc_clear: got %b, required 0", name, fc_at_start); end
        n_vec++;
        if (got.size() != NPIX) begin n_err++; $display("FAIL %s_count: got %0d outputs, required %0d", name, got.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            logic [7:0] act;
            act = (i < got.size()) ? got[i] : 8'hxx;
            n_vec++;
            if (act !== exp_q[i]) begin n_err++; $display("FAIL %s_pix[%0d]: got %h, required %h", name, i, act, exp_q[i]); end
        end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'h00;
        frame[3*W+3] = 8'hFF;
        test_frame("impulse", 0, 0);
        n_vec++;
        if (got.size() > 3*W+3 && got[3*W+3] !== 8'h00) begin
            n_err++; $display("FAIL impulse_removed: got %h, required 00", got[3*W+3]);
        end
    endtask

    task automatic test_border();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'h10;
        frame[0] = 8'hAA; frame[NPIX-1] = 8'hAA; frame[2*W] = 8'hFF;
        test_frame("border", 0, 0);
    endtask

    task automatic test_median_window();
        logic [7:0] win[9];
        win = '{8'h01, 8'h09, 8'h02, 8'h08, 8'h03, 8'h07, 8'h04, 8'h06, 8'h05};
        for (int i = 0; i < NPIX; i++) frame[i] = 8'h00;
        for (int i = 0; i < 9; i++) frame[(3+i/3)*W + 3 + i%3] = win[i];
        test_frame("window", 0, 0);
        // values 1..9 with duplicates counted: 5th smallest is 5
        n_vec++;
        if (got.size() > 4*W+4 && got[4*W+4] !== 8'h05) begin
            n_err++; $display("FAIL window_center: got %h, required 05", got[4*W+4]);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'(i);
        test_frame("ramp", 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'(i);
        test_frame("gaps", 3, 22);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++)
                frame[i] = (f == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            test_frame("random", 1, int'($urandom_range(0, 12)));
        end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            data_valid = 1'b1;
            data_in    = 8'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (data_valid_out !== 1'b0 || data_out !== 8'h00 || frame_complete !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: dvo=%b dout=%h fc=%b, required 0/00/0", data_valid_out, data_out, frame_complete);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NPIX; i++) frame[i] = 8'h33;
        test_frame("after_reset", 0, 0);
        n_vec++;
        if (frame_complete !== 1'b1) begin n_err++; $display("FAIL after_reset_fc: got %b, required 1", frame_complete); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; data_valid = 1'b0; data_in = '0;
        test_reset();
        test_constant();
        test_impulse();
        test_border();
        test_median_window();
        test_ramp();
        test_back_to_back();
        test_random();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
